// File: rtl/tbm_arbiter.sv
// Round-robin burst arbiter sharing one tbm memory port among NUM_REQ requesters.
// Sequences cs/we/address per beat, streams write data, and tags read returns back to the winner.
module tbm_arbiter #(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 256,
    parameter int LEN_W    = 8,
    parameter int READ_LAT = 2
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [NUM_REQ-1:0]          wdata_ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [NUM_REQ-1:0]          rdata_valid,
    output logic [NUM_REQ-1:0]          done,
    output logic                        mem_cs,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_address,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_winner, w_winner_nxt;
    logic                 r_we, w_we_nxt;
    logic [ADDR_W-1:0]    r_addr_cnt, w_addr_cnt_nxt;
    logic [LEN_W-1:0]     r_beat_cnt, w_beat_cnt_nxt;
    logic [IDX_W-1:0]     r_rr, w_rr_nxt;

    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [NUM_REQ-1:0]   r_wack, w_wack_nxt;
    logic [NUM_REQ-1:0]   r_done, w_done_nxt;
    logic                 r_mem_cs, w_mem_cs_nxt;
    logic                 r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]    r_mem_address, w_mem_address_nxt;

    logic [NUM_REQ-1:0]   r_pipe [READ_LAT];
    logic [DATA_W-1:0]    r_rdata_hold;
    logic                 w_pend_early;

    logic                 w_found;
    logic [IDX_W-1:0]     w_sel;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [LEN_W-1:0]     w_sel_len;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [IDX_W-1:0] idx);
        f_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Round-robin search: first requesting line strictly after the last winner.
    always_comb begin : rr_search
        int idx;
        idx        = 0;
        w_found    = 1'b0;
        w_sel      = r_rr;
        w_sel_we   = 1'b0;
        w_sel_addr = '0;
        w_sel_len  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_rr) + k) % NUM_REQ;
            if (!w_found && req[idx]) begin
                w_found    = 1'b1;
                w_sel      = IDX_W'(idx);
                w_sel_we   = req_we[idx];
                w_sel_addr = req_addr[idx*ADDR_W +: ADDR_W];
                w_sel_len  = req_len[idx*LEN_W +: LEN_W];
            end else begin
                w_found    = w_found;
            end
        end
    end

    // Read beats still travelling through the return pipe, excluding the stage issuing now.
    always_comb begin
        w_pend_early = 1'b0;
        for (int k = 0; k < READ_LAT - 1; k++) begin
            w_pend_early = w_pend_early | (|r_pipe[k]);
        end
    end

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        w_state_nxt    = r_state;
        w_winner_nxt   = r_winner;
        w_we_nxt       = r_we;
        w_addr_cnt_nxt = r_addr_cnt;
        w_beat_cnt_nxt = r_beat_cnt;
        w_rr_nxt       = r_rr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_winner_nxt   = w_sel;
                    w_we_nxt       = w_sel_we;
                    w_addr_cnt_nxt = w_sel_addr;
                    w_beat_cnt_nxt = w_sel_len;
                    w_state_nxt    = (w_sel_len == LEN_W'(0)) ? S_DONE : S_BURST;
                end else begin
                    w_state_nxt    = S_IDLE;
                end
            end
            S_BURST: begin
                w_addr_cnt_nxt = r_addr_cnt + ADDR_W'(1);
                w_beat_cnt_nxt = r_beat_cnt - LEN_W'(1);
                if (r_beat_cnt == LEN_W'(1)) begin
                    w_state_nxt = r_we ? S_DONE : S_DRAIN;
                end else begin
                    w_state_nxt = S_BURST;
                end
            end
            S_DRAIN: begin
                if (!w_pend_early) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                w_rr_nxt    = r_winner;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_gnt_nxt         = (w_state_nxt != S_IDLE) ? f_onehot(w_winner_nxt) : '0;
        w_mem_cs_nxt      = (w_state_nxt == S_BURST);
        w_mem_we_nxt      = w_mem_cs_nxt & w_we_nxt;
        w_mem_address_nxt = w_mem_cs_nxt ? w_addr_cnt_nxt : '0;
        w_wack_nxt        = (w_mem_cs_nxt && w_we_nxt) ? f_onehot(w_winner_nxt) : '0;
        w_done_nxt        = (w_state_nxt == S_DONE) ? f_onehot(w_winner_nxt) : '0;
    end

    // State, burst counters and registered port outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_winner      <= '0;
            r_we          <= 1'b0;
            r_addr_cnt    <= '0;
            r_beat_cnt    <= '0;
            r_rr          <= IDX_W'(NUM_REQ - 1);
            r_gnt         <= '0;
            r_wack        <= '0;
            r_done        <= '0;
            r_mem_cs      <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_address <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_winner      <= w_winner_nxt;
            r_we          <= w_we_nxt;
            r_addr_cnt    <= w_addr_cnt_nxt;
            r_beat_cnt    <= w_beat_cnt_nxt;
            r_rr          <= w_rr_nxt;
            r_gnt         <= w_gnt_nxt;
            r_wack        <= w_wack_nxt;
            r_done        <= w_done_nxt;
            r_mem_cs      <= w_mem_cs_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_address <= w_mem_address_nxt;
        end
    end

    // Tagged read-valid pipe; the last stage lines up with mem_rdata.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < READ_LAT; k++) begin
                r_pipe[k] <= '0;
            end
            r_rdata_hold <= '0;
        end else begin
            r_pipe[0] <= (r_mem_cs && !r_mem_we) ? r_gnt : '0;
            for (int k = 1; k < READ_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            if (|r_pipe[READ_LAT-1]) begin
                r_rdata_hold <= mem_rdata;
            end else begin
                r_rdata_hold <= r_rdata_hold;
            end
        end
    end

    assign gnt         = r_gnt;
    assign wdata_ack   = r_wack;
    assign done        = r_done;
    assign mem_cs      = r_mem_cs;
    assign mem_we      = r_mem_we;
    assign mem_address = r_mem_address;
    assign rdata_valid = r_pipe[READ_LAT-1];
    // Data buses pass through so the acked word and the returning word land in the same cycle.
    assign mem_wdata   = (|r_wack) ? req_wdata[int'(r_winner)*DATA_W +: DATA_W] : '0;
    assign rdata       = (|r_pipe[READ_LAT-1]) ? mem_rdata : r_rdata_hold;

endmodule

// File: doc/tbm_arbiter.md
Name: tbm_arbiter

Overview:
- Round-robin burst arbiter that shares one tbm memory port among NUM_REQ xfer_buffer-style requesters.
- Each requester posts a burst descriptor: direction, start address, beat count.
- The arbiter grants one requester at a time and sequences cs/we/address per beat. It streams write data from the winner or returns read data to it, then pulses a per-requester done.
- Sits in the clock_fpga domain between the transfer buffers and tbm.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ADDR_W, 32, memory address width.
- DATA_W, 256, memory word width.
- LEN_W, 8, burst length field width.
- READ_LAT, 2, cycles from a read beat (mem_cs=1, mem_we=0) to valid mem_rdata (1..4).

Ports:
- clock  in  1  fpga clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester burst request, level.
- req_we  in  NUM_REQ  1=write burst, 0=read burst; sampled with req.
- req_addr  in  NUM_REQ*ADDR_W  start address; slice i belongs to requester i.
- req_len  in  NUM_REQ*LEN_W  beat count; 0 = empty burst.
- req_wdata  in  NUM_REQ*DATA_W  current write word of each requester.
- gnt  out  NUM_REQ  one-hot grant, held for the whole burst.
- wdata_ack  out  NUM_REQ  one-hot; the granted slice of req_wdata is consumed this cycle; requester advances to its next word.
- rdata  out  DATA_W  read data forwarded from mem_rdata.
- rdata_valid  out  NUM_REQ  one-hot; rdata belongs to that requester this cycle.
- done  out  NUM_REQ  one-cycle completion pulse.
- mem_cs  out  1  memory chip select.
- mem_we  out  1  memory write enable.
- mem_address  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (reset=0, async):
  - All outputs 0 immediately.
  - State IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - Read-valid pipeline cleared. Any burst in flight is abandoned and no done is issued.
- States: IDLE, BURST, DRAIN, DONE.
- IDLE:
  - If any req bit is set, select the first set bit searching from rr+1 upward, modulo NUM_REQ.
  - Latch winner index, req_we, req_addr slice into addr_cnt, and req_len slice into beat_cnt.
  - Next cycle gnt[winner]=1.
  - Go to DONE if len==0, else BURST.
  - req is sampled only in IDLE. Changes to req/req_we/req_addr/req_len after latch are ignored.
- BURST, one beat per cycle:
  - mem_cs=1; mem_we=latched we; mem_address=addr_cnt.
  - Write: mem_wdata=req_wdata[winner] and wdata_ack[winner]=1, same cycle.
  - Read: mem_wdata=0 and wdata_ack=0.
  - Every beat: addr_cnt+=1 (wraps modulo 2^ADDR_W, no error); beat_cnt-=1.
  - When beat_cnt==1 in this cycle (last beat), next state is DONE for a write and DRAIN for a read.
- Read return path:
  - A READ_LAT-deep shift register carries a tagged valid per read beat.
  - When it emerges: rdata=mem_rdata and rdata_valid[tag]=1.
  - Read data arrives in beat order with exactly READ_LAT latency.
- DRAIN:
  - mem_cs=0.
  - Wait until the last read beat's rdata_valid has been issued (READ_LAT cycles after the last beat), then go to DONE.
- DONE, exactly 1 cycle:
  - done[winner]=1; gnt still asserted this cycle.
  - rr=winner; next IDLE, where gnt drops.
  - Requester must drop req in the DONE cycle. If req is still high in IDLE, it is a new burst.
- Burst spacing: minimum 2 idle-port cycles between bursts (DONE + IDLE). Back-to-back bursts alternate among active requesters; no requester waits more than NUM_REQ-1 bursts.
- Outputs are registered. mem_cs/mem_we/mem_address are 0 outside BURST. rdata holds its last value when rdata_valid=0.
- Simultaneous req rise on all lines: the winner is determined purely by rr.
- No abort: a requester dropping req mid-burst still receives the full burst and done.

Test Plan:
- Reset, then req[0]=1, we=1, addr=0x100, len=4, with req_wdata incrementing on wdata_ack.
  - mem_cs=1 for 4 consecutive cycles at addresses 0x100..0x103 carrying data 0..3.
  - wdata_ack[0] on the same 4 cycles.
  - done[0] pulse 1 cycle after the last beat.
- Read burst from req[1]: addr=0x100, len=4, READ_LAT=2, tbm model preloaded.
  - rdata_valid[1] for 4 cycles, starting 2 cycles after the first read beat, with data 0..3 in order.
  - done[1] after the last valid.
- req[0] and req[1] both held continuously, len=2 each.
  - Grant order 0,1,0,1 from reset.
  - gnt is never multi-hot.
  - Exactly 2 cycles with mem_cs=0 between bursts.
- len=0 request from req[1]: gnt[1] for 1 cycle, done[1] pulse, mem_cs never asserted.
- Write len=3 at addr=0xFFFFFFFF: mem_address sequence 0xFFFFFFFF, 0x00000000, 0x00000001.
- Assert reset=0 mid write burst (beat 2 of 8).
  - All outputs 0 asynchronously; no done.
  - After release, a fresh req[1]-only request is granted first.
